z80_regpair_incdec_seq: RTL and testbench
=========================================

Name: z80_regpair_incdec_seq

Overview:
- Parametrised register-pair bank (BC, DE, HL, SP) with an inc/dec engine and a block-transfer sequencer.
- Executes single INC/DEC dd operations in one cycle.
- Executes LDI/LDD-style steps (HL±1, DE±1, BC−1) and LDIR/LDDR-style repeats, with a configurable per-iteration cycle cost.
- Sits beside the Z80 core datapath and feeds final pair values and the block P/V condition back to the core.

Parameters:
- WIDTH, 16, width of each register pair. Arithmetic is modulo 2^WIDTH.
- STEP_CYCLES, 5, cycles per block iteration (models memory read/write time). Must be ≥1.

Ports:
- clk  input  1  clock
- reset_n  input  1  asynchronous active-low reset
- req_valid  input  1  operation request
- req_ready  output  1  block can accept a request this cycle
- req_op  input  2  00 INC, 01 DEC, 10 BLK (single block step), 11 BLKR (repeating block)
- req_sel  input  2  pair for INC/DEC: 0=BC, 1=DE, 2=HL, 3=SP (ignored for BLK/BLKR)
- req_dir  input  1  BLK/BLKR only: 0 HL/DE increment, 1 HL/DE decrement
- abort  input  1  stop BLKR after the current iteration (interrupt pending)
- load_en  input  1  write load_data into pair load_sel
- load_sel  input  2  pair select for load
- load_data  input  WIDTH  load value
- rd_sel  input  2  read select
- rd_data  output  WIDTH  combinational read of pair rd_sel (registered contents)
- busy  output  1  block sequencer active
- iter_valid  output  1  one-cycle pulse at the end of every block iteration
- done_valid  output  1  one-cycle pulse when an accepted operation completes
- done_value  output  WIDTH  INC/DEC: new pair value; BLK/BLKR: new BC
- done_zero  output  1  done_value == 0 (core derives P/V = !done_zero for block ops)

Behaviour:
- Reset (async, reset_n low): all pairs 0, FSM IDLE, busy=0, iter_valid=0, done_valid=0, done_value=0, done_zero=0, step counter 0. A reset mid-operation aborts instantly, with no done pulse.
- req_ready = (state==IDLE) && !load_en. Load has priority.
- Load: applied at the clock edge when load_en && state==IDLE. Ignored while busy.
- FSM states: IDLE, STEP, DONE.
- INC/DEC, accepted in IDLE:
  - Pair updated at the next edge.
  - done_valid high in the following cycle, done_value = new value, zero flag set accordingly.
  - State stays IDLE, so back-to-back INC/DEC sustain 1 op/cycle.
  - Wrap: all-ones+1=0, 0−1=all-ones.
- BLK/BLKR, accepted in IDLE:
  - Transition to STEP, busy=1, counter loads STEP_CYCLES−1, direction and op latched.
  - In STEP the counter decrements each cycle. When it reaches 0, the same edge performs BC−1 and HL,DE ±1 per latched direction, and iter_valid pulses the next cycle.
  - BLK: after one iteration go to DONE.
  - BLKR: after an iteration go to DONE if new BC==0 or abort was sampled high on that edge; otherwise reload the counter and remain in STEP.
  - BLKR with BC=0 at start runs 2^WIDTH iterations (Z80 semantics).
  - abort in IDLE has no effect. abort mid-iteration does not shorten the current iteration.
- DONE (one cycle): done_valid=1, done_value=BC, done_zero=(BC==0). busy stays high in DONE, then IDLE. req_ready is low in DONE.
- SP is never touched by BLK/BLKR. rd_data reflects updates the cycle after the edge.
- No simultaneous-update conflict exists, because loads are blocked while busy and requests are blocked while loading.

Test Plan:
- Load BC=0x0001; INC sel=0, then DEC sel=0 on consecutive cycles → done_value 0x0002 then 0x0001, done_zero 0/0, req_ready held high.
- Load SP=0xFFFF; INC sel=3 → SP=0x0000, done_zero=1. Then DEC sel=3 → SP=0xFFFF.
- Load BC=3, HL=0x1000, DE=0x2000; BLKR dir=0, STEP_CYCLES=5:
  - three iter_valid pulses 5 cycles apart;
  - done_valid 1 cycle after the 3rd pulse;
  - final BC=0, HL=0x1003, DE=0x2003, done_zero=1;
  - busy high throughout.
- BC=10, BLKR dir=1, abort pulsed during iteration 2 → exactly 2 iterations, BC=8, HL/DE decremented by 2, done_zero=0.
- Drive load_en with req_valid in IDLE → req_ready=0, load applied, request not accepted. Drive load_en while busy → pair unchanged.
- Pull reset_n low during BLKR iteration → all pairs 0, busy=0, no done_valid. After release, req_ready=1.

Source files
------------

// File: rtl/z80_regpair_incdec_seq.sv
// Z80 register-pair bank (BC, DE, HL, SP) with a one-cycle INC/DEC engine and
// an LDI/LDD/LDIR/LDDR block-step sequencer. It returns final values and the zero flag to the core.
module z80_regpair_incdec_seq #(
  parameter int WIDTH       = 16,
  parameter int STEP_CYCLES = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [1:0]       req_sel,
  input  logic             req_dir,
  input  logic             abort,
  input  logic             load_en,
  input  logic [1:0]       load_sel,
  input  logic [WIDTH-1:0] load_data,
  input  logic [1:0]       rd_sel,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             iter_valid,
  output logic             done_valid,
  output logic [WIDTH-1:0] done_value,
  output logic             done_zero
);

  localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STEP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, STEP, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] pairs [4];
  logic [CNT_W-1:0] cnt;
  logic             dir_q, rep_q, abort_pend;
  logic             accept, iter_end;
  logic [WIDTH-1:0] bc_next, incdec_next;

  function automatic logic [WIDTH-1:0] bump(input logic [WIDTH-1:0] v, input logic down);
    return down ? (v - WIDTH'(1)) : (v + WIDTH'(1));
  endfunction

  assign rd_data     = pairs[rd_sel];
  assign accept      = req_valid && req_ready;
  assign iter_end    = (state == STEP) && (cnt == '0);
  assign bc_next     = bump(pairs[0], 1'b1);
  assign incdec_next = bump(pairs[req_sel], req_op[0]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // An abort latched at any point in an iteration ends BLKR at that iteration's end.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept && req_op[1]) state_next = STEP;
      STEP: if (iter_end && (!rep_q || (bc_next == '0) || abort || abort_pend))
              state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE) && !load_en;
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) pairs[i] <= '0;
      cnt        <= '0;
      dir_q      <= 1'b0;
      rep_q      <= 1'b0;
      abort_pend <= 1'b0;
      iter_valid <= 1'b0;
      done_valid <= 1'b0;
      done_value <= '0;
      done_zero  <= 1'b0;
    end else begin
      iter_valid <= iter_end;
      done_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (load_en) begin
            pairs[load_sel] <= load_data;
          end else if (accept && !req_op[1]) begin
            pairs[req_sel] <= incdec_next;
            done_valid     <= 1'b1;
            done_value     <= incdec_next;
            done_zero      <= (incdec_next == '0);
          end else if (accept) begin
            cnt        <= CNT_LOAD;
            dir_q      <= req_dir;
            rep_q      <= req_op[0];
            abort_pend <= 1'b0;
          end
        end
        STEP: begin
          if (abort) abort_pend <= 1'b1;
          if (cnt == '0) begin
            pairs[0] <= bc_next;
            pairs[1] <= bump(pairs[1], dir_q);
            pairs[2] <= bump(pairs[2], dir_q);
            cnt      <= CNT_LOAD;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          done_valid <= 1'b1;
          done_value <= pairs[0];
          done_zero  <= (pairs[0] == '0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_z80_regpair_incdec_seq.sv
// Directed bench for z80_regpair_incdec_seq: INC/DEC, block steps and repeats, abort,
// load priority, and asynchronous reset.
module tb_z80_regpair_incdec_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_dir, abort, load_en;
  logic [1:0]  req_op, req_sel, load_sel, rd_sel;
  logic [15:0] load_data, rd_data, done_value;
  logic        busy, iter_valid, done_valid, done_zero;

  int errors = 0;
  int checks = 0;

  int it_cnt, done_cyc, busy_bad;
  int it_cyc [3];
  logic [15:0] dv;
  logic dz;

  always #10 clk = ~clk;

  z80_regpair_incdec_seq #(.WIDTH(16), .STEP_CYCLES(5)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_sel(req_sel), .req_dir(req_dir), .abort(abort),
    .load_en(load_en), .load_sel(load_sel), .load_data(load_data), .rd_sel(rd_sel),
    .rd_data(rd_data), .busy(busy), .iter_valid(iter_valid), .done_valid(done_valid),
    .done_value(done_value), .done_zero(done_zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] sel, input logic [15:0] exp);
    rd_sel = sel;
    #1;
    chk(tag, 32'(rd_data), 32'(exp));
  endtask

  task automatic do_load(input logic [1:0] sel, input logic [15:0] data);
    load_en = 1'b1; load_sel = sel; load_data = data;
    tick();
    load_en = 1'b0;
  endtask

  // Accept edge is tick 0; records tick indices of iter/done pulses up to maxk.
  task automatic run_blk(input int maxk, input int abort_at, input int busy_until);
    it_cnt = 0; done_cyc = -1; busy_bad = 0; dv = '0; dz = 1'b0;
    for (int k = 1; k <= maxk; k++) begin
      tick();
      abort = (k == abort_at);
      if (iter_valid) begin
        if (it_cnt < 3) it_cyc[it_cnt] = k;
        it_cnt++;
      end
      if (done_valid && done_cyc < 0) begin
        done_cyc = k; dv = done_value; dz = done_zero;
      end
      if (k <= busy_until && !busy) busy_bad++;
    end
    abort = 1'b0;
  endtask

  task automatic start_blk(input logic rep, input logic dir);
    req_valid = 1'b1; req_op = {1'b1, rep}; req_dir = dir; req_sel = 2'd0;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_op = '0; req_sel = '0; req_dir = 1'b0;
    abort = 1'b0; load_en = 1'b0; load_sel = '0; load_data = '0; rd_sel = '0;
    #25;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done_valid", 32'(done_valid), 0);
    chk("rst_done_value", 32'(done_value), 0);
    chk("rst_iter_valid", 32'(iter_valid), 0);
    rd_chk("rst_bc", 2'd0, 16'h0000);
    rd_chk("rst_sp", 2'd3, 16'h0000);
    #4 reset_n = 1'b1;
    tick();
    chk("rst_ready", 32'(req_ready), 1);

    // INC then DEC of BC back-to-back
    do_load(2'd0, 16'h0001);
    req_valid = 1'b1; req_op = 2'b00; req_sel = 2'd0;
    #1 chk("inc_ready", 32'(req_ready), 1);
    tick();
    chk("inc_done_valid", 32'(done_valid), 1);
    chk("inc_done_value", 32'(done_value), 32'h0002);
    chk("inc_done_zero", 32'(done_zero), 0);
    req_op = 2'b01;
    #1 chk("dec_ready", 32'(req_ready), 1);
    tick();
    chk("dec_done_valid", 32'(done_valid), 1);
    chk("dec_done_value", 32'(done_value), 32'h0001);
    chk("dec_done_zero", 32'(done_zero), 0);
    req_valid = 1'b0;
    tick();
    chk("idle_done_valid", 32'(done_valid), 0);
    rd_chk("bc_after_incdec", 2'd0, 16'h0001);

    // SP wrap in both directions
    do_load(2'd3, 16'hFFFF);
    req_valid = 1'b1; req_op = 2'b00; req_sel = 2'd3;
    tick();
    chk("sp_inc_value", 32'(done_value), 32'h0000);
    chk("sp_inc_zero", 32'(done_zero), 1);
    req_op = 2'b01;
    tick();
    req_valid = 1'b0;
    chk("sp_dec_value", 32'(done_value), 32'hFFFF);
    chk("sp_dec_zero", 32'(done_zero), 0);
    rd_chk("sp_rd", 2'd3, 16'hFFFF);

    // LDIR: BC=3, incrementing
    do_load(2'd0, 16'd3);
    do_load(2'd2, 16'h1000);
    do_load(2'd1, 16'h2000);
    start_blk(1'b1, 1'b0);
    chk("ldir_busy0", 32'(busy), 1);
    chk("ldir_ready0", 32'(req_ready), 0);
    run_blk(30, 0, 15);
    chk("ldir_iters", 32'(it_cnt), 3);
    chk("ldir_it1", 32'(it_cyc[0]), 5);
    chk("ldir_it2", 32'(it_cyc[1]), 10);
    chk("ldir_it3", 32'(it_cyc[2]), 15);
    chk("ldir_done_cyc", 32'(done_cyc), 16);
    chk("ldir_busy", 32'(busy_bad), 0);
    chk("ldir_done_value", 32'(dv), 0);
    chk("ldir_done_zero", 32'(dz), 1);
    rd_chk("ldir_bc", 2'd0, 16'h0000);
    rd_chk("ldir_hl", 2'd2, 16'h1003);
    rd_chk("ldir_de", 2'd1, 16'h2003);
    rd_chk("ldir_sp", 2'd3, 16'hFFFF);

    // LDDR aborted during the second iteration
    do_load(2'd0, 16'd10);
    do_load(2'd2, 16'h5000);
    do_load(2'd1, 16'h6000);
    start_blk(1'b1, 1'b1);
    run_blk(25, 7, 10);
    chk("lddr_iters", 32'(it_cnt), 2);
    chk("lddr_done_cyc", 32'(done_cyc), 11);
    chk("lddr_busy", 32'(busy_bad), 0);
    chk("lddr_done_value", 32'(dv), 8);
    chk("lddr_done_zero", 32'(dz), 0);
    rd_chk("lddr_bc", 2'd0, 16'd8);
    rd_chk("lddr_hl", 2'd2, 16'h4FFE);
    rd_chk("lddr_de", 2'd1, 16'h5FFE);

    // Load wins over a simultaneous request
    load_en = 1'b1; load_sel = 2'd1; load_data = 16'h1234;
    req_valid = 1'b1; req_op = 2'b00; req_sel = 2'd2;
    #1 chk("load_blocks_ready", 32'(req_ready), 0);
    tick();
    load_en = 1'b0; req_valid = 1'b0;
    chk("load_no_done", 32'(done_valid), 0);
    rd_chk("load_de", 2'd1, 16'h1234);
    rd_chk("load_hl_kept", 2'd2, 16'h4FFE);

    // Single LDI with a load attempt while busy
    start_blk(1'b0, 1'b0);
    load_en = 1'b1; load_sel = 2'd3; load_data = 16'hAAAA;
    tick();
    load_en = 1'b0;
    run_blk(15, 0, 0);
    chk("ldi_iters", 32'(it_cnt), 1);
    chk("ldi_done_cyc", 32'(done_cyc), 5);
    chk("ldi_done_value", 32'(dv), 7);
    rd_chk("ldi_sp_kept", 2'd3, 16'hFFFF);
    rd_chk("ldi_hl", 2'd2, 16'h4FFF);
    rd_chk("ldi_de", 2'd1, 16'h1235);

    // Asynchronous reset in the middle of LDIR
    do_load(2'd0, 16'd5);
    start_blk(1'b1, 1'b0);
    run_blk(7, 0, 7);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done_valid", 32'(done_valid), 0);
    rd_chk("mid_rst_bc", 2'd0, 16'h0000);
    rd_chk("mid_rst_hl", 2'd2, 16'h0000);
    rd_chk("mid_rst_sp", 2'd3, 16'h0000);
    tick();
    chk("mid_rst_hold_done", 32'(done_valid), 0);
    #4 reset_n = 1'b1;
    #1 chk("post_rst_ready", 32'(req_ready), 1);
    run_blk(12, 0, 0);
    chk("post_rst_no_done", 32'(done_cyc), 32'hFFFFFFFF);
    chk("post_rst_no_iter", 32'(it_cnt), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
